// File: rtl/mem_responder_if.sv
// CPU memory-initiator bus: request strobes, byte enables, address and write data
// from the CPU; completion pulse and read data back from the memory side.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering the CPU memory-initiator bus with a fixed,
// parameterised response latency, a sticky protocol-violation flag and completion counters.
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus,
    output logic           protocol_error,
    output logic [15:0]    read_count,
    output logic [15:0]    write_count
);

    localparam int         DEPTH       = 2 ** ADDR_BITS;
    localparam logic [3:0] WAIT_CYCLES = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_next_s;

    logic                 op_write_r;
    logic [ADDR_BITS-1:0] idx_r;
    logic [3:0]           be_r;
    logic [31:0]          wdata_r;

    logic                 accept_s;
    logic                 err_set_s;
    logic                 latched_strobe_s;
    logic                 other_strobe_s;
    logic [ADDR_BITS-1:0] addr_idx_s;
    logic [ADDR_BITS-1:0] rd_idx_s;
    logic                 rd_op_write_s;
    logic                 addr_unused_s;

    logic                 mem_resp_r;
    logic [31:0]          mem_rdata_r;
    logic                 protocol_error_r;
    logic [15:0]          read_count_r;
    logic [15:0]          write_count_r;

    logic [31:0]          mem_r [DEPTH] = '{default: 32'h0000_0000};

    // Byte-offset bits and bits above the word index are dropped, so addresses alias.
    assign addr_idx_s    = bus.mem_address[ADDR_BITS+1:2];
    assign addr_unused_s = ^{bus.mem_address[31:ADDR_BITS+2], bus.mem_address[1:0]};

    assign latched_strobe_s = op_write_r ? bus.mem_write : bus.mem_read;
    assign other_strobe_s   = op_write_r ? bus.mem_read  : bus.mem_write;

    // With LATENCY=1 the request goes straight from IDLE to RESP, so the read
    // port must look at the request being accepted rather than the latched one.
    assign rd_idx_s      = accept_s ? addr_idx_s    : idx_r;
    assign rd_op_write_s = accept_s ? bus.mem_write : op_write_r;

    // State and latency counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, acceptance and violation detection.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    err_set_s = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    accept_s     = 1'b1;
                    cnt_next_s   = WAIT_CYCLES;
                    state_next_s = (WAIT_CYCLES == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A switched strobe is flagged but the original op still completes;
                // only a request with no strobe at all is abandoned.
                if (!latched_strobe_s && !other_strobe_s) begin
                    err_set_s    = 1'b1;
                    cnt_next_s   = 4'd0;
                    state_next_s = ST_IDLE;
                end else begin
                    err_set_s = other_strobe_s;
                    if (cnt_r <= 4'd1) begin
                        cnt_next_s   = 4'd0;
                        state_next_s = ST_RESP;
                    end else begin
                        cnt_next_s   = cnt_r - 4'd1;
                    end
                end
            end
            ST_RESP: begin
                cnt_next_s   = 4'd0;
                state_next_s = ST_IDLE;
            end
            default: begin
                cnt_next_s   = 4'd0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request capture at acceptance; later changes on the bus are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write_r <= 1'b0;
            idx_r      <= '0;
            be_r       <= 4'd0;
            wdata_r    <= 32'd0;
        end else if (accept_s) begin
            op_write_r <= bus.mem_write;
            idx_r      <= addr_idx_s;
            be_r       <= bus.mem_byte_enable;
            wdata_r    <= bus.mem_wdata;
        end
    end

    // Registered response, read data, error flag and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_resp_r       <= 1'b0;
            mem_rdata_r      <= 32'd0;
            protocol_error_r <= 1'b0;
            read_count_r     <= 16'd0;
            write_count_r    <= 16'd0;
        end else begin
            mem_resp_r <= (state_next_s == ST_RESP);
            if (state_next_s == ST_RESP && !rd_op_write_s) begin
                mem_rdata_r <= mem_r[rd_idx_s];
            end
            if (err_set_s) begin
                protocol_error_r <= 1'b1;
            end
            if (state_r == ST_RESP) begin
                if (op_write_r && write_count_r != 16'hFFFF) begin
                    write_count_r <= write_count_r + 16'd1;
                end
                if (!op_write_r && read_count_r != 16'hFFFF) begin
                    read_count_r <= read_count_r + 16'd1;
                end
            end
        end
    end

    // Write commit at the end of the RESP cycle; a reset in that cycle drops it.
    always_ff @(posedge clk) begin
        if (!rst && state_r == ST_RESP && op_write_r) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_resp    = mem_resp_r;
    assign bus.mem_rdata   = mem_rdata_r;
    assign protocol_error  = protocol_error_r;
    assign read_count      = read_count_r;
    assign write_count     = write_count_r;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with different latencies share one stimulus
// bus (only the selected one sees strobes) and are checked against an array memory model.
module tb_mem_responder;
    localparam int NDUT = 4;
    localparam int LAT_TAB [NDUT] = '{3, 1, 15, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [NDUT-1:0] resp_v;
    logic [NDUT-1:0] perr_v;
    logic [31:0]     rdata_v [NDUT];
    logic [15:0]     rcnt_v  [NDUT];
    logic [15:0]     wcnt_v  [NDUT];

    mem_responder_if bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign bus[g].mem_read        = rd && (sel == g);
        assign bus[g].mem_write       = wr && (sel == g);
        assign bus[g].mem_byte_enable = be;
        assign bus[g].mem_address     = addr;
        assign bus[g].mem_wdata       = wdata;
        assign resp_v[g]              = bus[g].mem_resp;
        assign rdata_v[g]             = bus[g].mem_rdata;

        mem_responder #(.ADDR_BITS(10), .LATENCY(LAT_TAB[g])) u_dut (
            .clk            (clk),
            .rst            (rst),
            .bus            (bus[g]),
            .protocol_error (perr_v[g]),
            .read_count     (rcnt_v[g]),
            .write_count    (wcnt_v[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model: plain word arrays and counters per instance.
    logic [31:0] model_mem [NDUT][1024];
    logic [31:0] m_last_rd [NDUT];
    int          m_rcnt    [NDUT];
    int          m_wcnt    [NDUT];
    bit          m_err     [NDUT];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_status(input int k);
        check($sformatf("perr[%0d]", k), 32'(perr_v[k]), 32'(m_err[k]));
        check($sformatf("read_count[%0d]", k), 32'(rcnt_v[k]), 32'(m_rcnt[k]));
        check($sformatf("write_count[%0d]", k), 32'(wcnt_v[k]), 32'(m_wcnt[k]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_last_rd[k] = 32'd0;
            m_rcnt[k]    = 0;
            m_wcnt[k]    = 0;
            m_err[k]     = 1'b0;
        end
    endtask

    task automatic check_reset_all(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check({tag, "_resp"}, 32'(resp_v[k]), 32'd0);
            check({tag, "_rdata"}, rdata_v[k], 32'd0);
            check_status(k);
        end
    endtask

    // One complete transaction: latency, response width, data and counters are all checked.
    task automatic do_txn(input int k, input bit is_wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        int          waited;
        logic [9:0]  idx;
        logic [31:0] mask;
        logic [31:0] old;
        idx = a[11:2];
        old = model_mem[k][idx];
        @(negedge clk);
        sel = k; addr = a; wdata = d; be = b; rd = !is_wr; wr = is_wr;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!resp_v[k] && waited < 40);
        rd = 1'b0;
        wr = 1'b0;
        check("latency", 32'(waited), 32'(LAT_TAB[k]));
        check("resp", 32'(resp_v[k]), 32'd1);
        if (is_wr) begin
            mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            model_mem[k][idx] = (old & ~mask) | (d & mask);
            m_wcnt[k]++;
            check("rdata_hold", rdata_v[k], m_last_rd[k]);
        end else begin
            m_last_rd[k] = old;
            m_rcnt[k]++;
            check("rdata", rdata_v[k], old);
        end
        @(negedge clk);
        check("resp_width", 32'(resp_v[k]), 32'd0);
        check_status(k);
    endtask

    // Read strobe held across several completions: spacing must be LATENCY+1.
    task automatic held_reads(input int k, input logic [31:0] a, input int n);
        int cyc;
        int last;
        int got;
        int exp_gap;
        logic [31:0] exp;
        exp = model_mem[k][a[11:2]];
        @(negedge clk);
        sel = k; addr = a; rd = 1'b1; wr = 1'b0;
        cyc = 0; last = 0; got = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (resp_v[k]) begin
                got++;
                exp_gap = (got == 1) ? LAT_TAB[k] : LAT_TAB[k] + 1;
                check("b2b_gap", 32'(cyc - last), 32'(exp_gap));
                check("b2b_rdata", rdata_v[k], exp);
                m_rcnt[k]++;
                m_last_rd[k] = exp;
                last = cyc;
                if (got == n) rd = 1'b0;
            end
        end
        rd = 1'b0;
        check("b2b_count", 32'(got), 32'(n));
        @(negedge clk);
        check("b2b_resp_low", 32'(resp_v[k]), 32'd0);
        check_status(k);
    endtask

    initial begin
        int          waited;
        logic [31:0] r;
        rd = 1'b0; wr = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0; sel = 0; rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 1024; i++) model_mem[k][i] = 32'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_all("reset");
        rst = 1'b0;

        // Both strobes for two cycles on the LATENCY=15 instance.
        sel = 2; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        check("both_resp0", 32'(resp_v[2]), 32'd0);
        check("both_perr", 32'(perr_v[2]), 32'd1);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        m_err[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("both_resp", 32'(resp_v[2]), 32'd0);
        end
        check_status(2);

        // Single write then read, LATENCY=3.
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        check("wr_rd_value", rdata_v[0], 32'hDEADBEEF);

        // Byte-enable merge; the read address 0x12 carries ignored low bits.
        do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b1111);
        do_txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
        do_txn(0, 1'b0, 32'h12, 32'h0, 4'b0000);
        check("be_merge", rdata_v[0], 32'h11BB33DD);

        // be=0000 write counts but leaves memory unchanged.
        do_txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);
        check("be_zero", rdata_v[0], 32'h11BB33DD);

        // Latency sweep with held read strobes.
        do_txn(1, 1'b1, 32'h8, 32'h0BADF00D, 4'b1111);
        held_reads(1, 32'h8, 3);
        do_txn(2, 1'b1, 32'h8, 32'h12345678, 4'b1111);
        held_reads(2, 32'h8, 2);

        // Abort mid-write on the LATENCY=4 instance.
        @(negedge clk);
        sel = 3; addr = 32'h20; wdata = 32'h55555555; be = 4'b1111; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        m_err[3] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_resp", 32'(resp_v[3]), 32'd0);
        end
        check_status(3);
        do_txn(3, 1'b0, 32'h20, 32'h0, 4'b0000);
        check("abort_old", rdata_v[3], 32'h00000000);

        // Strobe switch read->write in WAIT: flagged, read still completes.
        @(negedge clk);
        sel = 0; addr = 32'h10; wdata = 32'hCAFECAFE; be = 4'b1111; rd = 1'b1; wr = 1'b0;
        @(negedge clk);
        waited = 1;
        rd = 1'b0; wr = 1'b1;
        while (!resp_v[0] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        wr = 1'b0;
        check("switch_latency", 32'(waited), 32'd3);
        check("switch_rdata", rdata_v[0], 32'h11BB33DD);
        m_err[0] = 1'b1;
        m_rcnt[0]++;
        m_last_rd[0] = 32'h11BB33DD;
        @(negedge clk);
        check_status(0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0000);

        // Reset while a write waits: nothing is written and outputs clear.
        @(negedge clk);
        sel = 0; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'b1111; wr = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset_all("midreset");
        rst = 1'b0; wr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midreset_resp", 32'(resp_v[0]), 32'd0);
        end
        do_txn(0, 1'b0, 32'h40, 32'h0, 4'b0000);
        check("midreset_nowrite", rdata_v[0], 32'h00000000);

        // Address aliasing with ADDR_BITS=10.
        do_txn(0, 1'b1, 32'h00001000, 32'h1, 4'b1111);
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        check("alias", rdata_v[0], 32'h00000001);

        // Randomised transactions over a small aliased window.
        for (int n = 0; n < 60; n++) begin
            r = $urandom();
            do_txn(int'($urandom_range(0, NDUT - 1)), bit'($urandom_range(0, 1)),
                   {r[31:12], 6'd0, r[5:0]}, $urandom(), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port word memory that answers the CPU's memory-initiator interface: mem_read/mem_write strobes, byte enables, address and write data in; mem_resp and mem_rdata out.
- Sits opposite the cpu top level in the unit testbench and the FPGA bring-up top, standing in for the cache/arbiter.
- Response latency is programmable, protocol violations are flagged, and completed transactions are counted.

Parameters:
- ADDR_BITS, 10, word-index width; depth = 2**ADDR_BITS 32-bit words (4 KiB default).
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read strobe; held until mem_resp.
- mem_write  input  1  write strobe; held until mem_resp.
- mem_byte_enable  input  4  write byte lanes; bit i enables wdata[8i+7:8i].
- mem_address  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  32  read data; valid in the mem_resp cycle.
- protocol_error  output  1  sticky violation flag.
- read_count  output  16  completed reads, saturating.
- write_count  output  16  completed writes, saturating.

Behaviour:
- Reset values:
  - mem_resp=0, mem_rdata=0, protocol_error=0, read_count=0, write_count=0.
  - State goes to IDLE and the latency counter to 0.
  - Memory contents are untouched by rst and are zero at time 0.
- Indexing:
  - Word index = mem_address[ADDR_BITS+1:2].
  - Bits [1:0] and bits above ADDR_BITS+1 are ignored, so out-of-range addresses alias.
- IDLE:
  - Exactly one strobe high: latch op, index, byte_enable and wdata; load cnt=LATENCY-1; go to WAIT. This cycle is T.
  - Both strobes high: set protocol_error, accept nothing, stay in IDLE.
- WAIT:
  - Decrement cnt each cycle.
  - Go to RESP when cnt==0 at the clock edge, so LATENCY=1 gives RESP in T+1.
  - mem_resp is asserted in cycle T+LATENCY.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Read: mem_rdata = mem[index], registered output.
  - Write: commit the enabled lanes at the end of the RESP cycle; mem_rdata holds its previous value.
  - Increment the matching counter unless it is at 0xFFFF.
  - Go to IDLE unconditionally.
  - A request present in the IDLE cycle after RESP is accepted as new; the minimum back-to-back spacing is LATENCY+1 cycles.
- Abort:
  - If the latched strobe is low in any WAIT cycle, set protocol_error and return to IDLE next cycle.
  - Nothing is written, no mem_resp is issued, and no counter changes.
- Strobe switch: if the op changes (read to write or write to read) during WAIT, set protocol_error, but complete the originally latched op.
- Latched fields:
  - Address, data and byte-enable changes during WAIT are ignored.
  - The CPU is required to hold them; the bench checks this separately.
- mem_byte_enable:
  - Ignored for reads.
  - A write with be=0000 still completes and counts but modifies nothing.
- protocol_error clears only on rst.
- rst asserted in any state:
  - Any pending write is dropped.
  - mem_resp is low in the following cycle.

Test Plan:
- Single write then read:
  - Stimulus: LATENCY=3. Write addr 0x10, data 0xDEADBEEF, be=1111 at T0. Then read 0x10.
  - Response: mem_resp at T0+3. Read mem_resp at its T+3 with rdata=0xDEADBEEF. read_count=1, write_count=1.
- Byte-enable merge:
  - Stimulus: mem[4]=0x11223344 (word 4, byte address 0x10). Write 0xAABBCCDD to 0x10 with be=0101. Then read 0x12, whose low bits are ignored.
  - Response: rdata=0x11BB33DD.
- Latency sweep:
  - Stimulus: LATENCY=1 and LATENCY=15, with read requests held.
  - Response: mem_resp exactly 1 and 15 cycles after acceptance, one cycle wide. Back-to-back reads complete every LATENCY+1 cycles.
- Both strobes:
  - Stimulus: mem_read=mem_write=1 for 2 cycles.
  - Response: no mem_resp, protocol_error=1 from the next cycle and sticky, counters stay 0.
- Abort mid-write:
  - Stimulus: write 0x55555555 to 0x20, strobe dropped at T+1 (LATENCY=4). Then read 0x20.
  - Response: protocol_error=1, no mem_resp for the write, read returns the old value 0x00000000.
- Reset mid-operation and aliasing:
  - Stimulus: rst in WAIT of a write. Later, write 0x1 to 0x00001000 with ADDR_BITS=10, then read 0x0.
  - Response: after reset, outputs are zero and no write occurred. The final read returns 0x1 (alias).
